md_iteration_sequencer: RTL

- Top-level run sequencer for the range-limited MD core.
- Launches each timestep and tracks per-PE reference-particle writeback completion.
- Waits a fixed drain window for ring-interconnect packets, then fires motion update once all force writes have landed; repeats for a programmed number of iterations.
- Sits between the broadcast controller, PE array, ring, force caches and motion-update control, replacing ad-hoc glue logic in the top level.

---
 rtl/md_iteration_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/md_iteration_sequencer.sv
// md_iteration_sequencer: run sequencer for the range-limited MD core.
// Launches each timestep, tracks per-PE reference-particle writeback, waits a
// fixed drain window for ring traffic, then fires motion update once every
// force write has landed. Repeats for a programmed number of iterations.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, num_iters          begin a run of num_iters timesteps (0 = immediate run_done)
//   reading_done_all          broadcast controller: all PEs finished reading
//   filter_buffer_empty_all   all PE filter buffers empty
//   force_cache_buf_empty     all force-cache input buffers empty
//   force_wr_enable           ring-to-force-cache write strobes, one per cell
//   ref_wb_issued             per-PE ref force writeback pulse
//   goto_next_ref             broadcast controller: advance to next ref particle
//   mu_done                   motion update finished pulse
//   iter_start                one-cycle pulse, timestep launch
//   all_ref_wb_issued         every PE has issued the current ref writeback
//   interconnect_empty        drain window elapsed
//   all_force_wr_issued       combinational AND of all completion conditions (FORCE only)
//   motion_update_start       one-cycle pulse to motion-update control
//   busy                      sequencer not idle
//   run_done                  one-cycle pulse when the run completes
//   iter_count                completed iterations in the current run
//   watchdog_err              sticky stall flag (only with MD_SEQ_WATCHDOG_EN)
//
// Optional feature: define MD_SEQ_WATCHDOG_EN to add a stall watchdog on FORCE
// and MU_WAIT (parameter WATCHDOG_CYCLES, output watchdog_err).
module md_iteration_sequencer #(
  parameter int unsigned NUM_CELLS    = 64,
  parameter int unsigned DRAIN_CYCLES = 64,
  parameter int unsigned ITER_WIDTH   = 16
`ifdef MD_SEQ_WATCHDOG_EN
  , parameter int unsigned WATCHDOG_CYCLES = 1048576
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] num_iters,
  input  logic                  reading_done_all,
  input  logic                  filter_buffer_empty_all,
  input  logic                  force_cache_buf_empty,
  input  logic [NUM_CELLS-1:0]  force_wr_enable,
  input  logic [NUM_CELLS-1:0]  ref_wb_issued,
  input  logic                  goto_next_ref,
  input  logic                  mu_done,
  output logic                  iter_start,
  output logic                  all_ref_wb_issued,
  output logic                  interconnect_empty,
  output logic                  all_force_wr_issued,
  output logic                  motion_update_start,
  output logic                  busy,
  output logic                  run_done,
  output logic [ITER_WIDTH-1:0] iter_count
`ifdef MD_SEQ_WATCHDOG_EN
  , output logic                watchdog_err
`endif
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, FORCE, MU_WAIT} state_t;

  state_t                state, state_nx;
  logic [NUM_CELLS-1:0]  cap, cap_nx;
  logic [DRAIN_W-1:0]    drain_cnt, drain_nx;
  logic [ITER_WIDTH-1:0] target, target_nx, iter_count_nx;
  logic                  all_ref_nx, ie_nx;
  logic                  iter_start_nx, mu_start_nx, run_done_nx;

`ifdef MD_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt, wd_nx;
  logic            wd_err_nx;
`endif

  // Completion AND; only meaningful while collecting forces.
  assign all_force_wr_issued = (state == FORCE) && (force_wr_enable == '0) &&
                               force_cache_buf_empty && filter_buffer_empty_all &&
                               all_ref_wb_issued && interconnect_empty;

  // Next-state and registered-output logic.
  always_comb begin
    state_nx      = state;
    cap_nx        = cap;
    drain_nx      = drain_cnt;
    all_ref_nx    = all_ref_wb_issued;
    target_nx     = target;
    iter_count_nx = iter_count;
    iter_start_nx = 1'b0;
    mu_start_nx   = 1'b0;
    run_done_nx   = 1'b0;
`ifdef MD_SEQ_WATCHDOG_EN
    wd_nx         = '0;
    wd_err_nx     = watchdog_err;
`endif

    case (state)
      IDLE: begin
        cap_nx     = '0;
        drain_nx   = '0;
        all_ref_nx = 1'b0;
        if (start) begin
          iter_count_nx = '0;
          if (num_iters != '0) begin
            target_nx     = num_iters;
            state_nx      = LAUNCH;
            iter_start_nx = 1'b1;
          end else begin
            run_done_nx = 1'b1;
          end
        end
      end

      LAUNCH: begin
        cap_nx     = '0;
        drain_nx   = '0;
        all_ref_nx = 1'b0;
        state_nx   = FORCE;
      end

      FORCE: begin
        if (goto_next_ref) begin
          // Writebacks landing in the clearing cycle belong to the next ref.
          cap_nx     = ref_wb_issued;
          drain_nx   = '0;
          all_ref_nx = 1'b0;
        end else begin
          cap_nx = cap | ref_wb_issued;
          if (!all_ref_wb_issued && (&cap_nx)) begin
            all_ref_nx = 1'b1;
            drain_nx   = '0;
          end else if (all_ref_wb_issued && (drain_cnt != DRAIN_W'(DRAIN_CYCLES))) begin
            drain_nx = drain_cnt + DRAIN_W'(1);
          end
        end
        if (reading_done_all && all_force_wr_issued) begin
          state_nx    = MU_WAIT;
          mu_start_nx = 1'b1;
        end
      end

      MU_WAIT: begin
        cap_nx     = '0;
        drain_nx   = '0;
        all_ref_nx = 1'b0;
        if (mu_done) begin
          iter_count_nx = iter_count + ITER_WIDTH'(1);
          if (iter_count_nx == target) begin
            state_nx    = IDLE;
            run_done_nx = 1'b1;
          end else begin
            state_nx      = LAUNCH;
            iter_start_nx = 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase

`ifdef MD_SEQ_WATCHDOG_EN
    // Stall detector: counts cycles spent without a state change.
    if (state == IDLE && start) begin
      wd_err_nx = 1'b0;
    end
    if ((state == FORCE || state == MU_WAIT) && (state_nx == state)) begin
      if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
        state_nx  = IDLE;
        wd_err_nx = 1'b1;
      end else begin
        wd_nx = wd_cnt + WD_W'(1);
      end
    end
`endif

    ie_nx = all_ref_nx && (drain_nx == DRAIN_W'(DRAIN_CYCLES));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      cap                 <= '0;
      drain_cnt           <= '0;
      target              <= '0;
      iter_count          <= '0;
      all_ref_wb_issued   <= 1'b0;
      interconnect_empty  <= 1'b0;
      iter_start          <= 1'b0;
      motion_update_start <= 1'b0;
      run_done            <= 1'b0;
      busy                <= 1'b0;
`ifdef MD_SEQ_WATCHDOG_EN
      wd_cnt              <= '0;
      watchdog_err        <= 1'b0;
`endif
    end else begin
      state               <= state_nx;
      cap                 <= cap_nx;
      drain_cnt           <= drain_nx;
      target              <= target_nx;
      iter_count          <= iter_count_nx;
      all_ref_wb_issued   <= all_ref_nx;
      interconnect_empty  <= ie_nx;
      iter_start          <= iter_start_nx;
      motion_update_start <= mu_start_nx;
      run_done            <= run_done_nx;
      busy                <= (state_nx != IDLE);
`ifdef MD_SEQ_WATCHDOG_EN
      wd_cnt              <= wd_nx;
      watchdog_err        <= wd_err_nx;
`endif
    end
  end

endmodule
